// File: rtl/softmax_stream.sv
// softmax_stream: argmax scan, exp ROM lookup with running sum, and restoring-divider normalisation
// States: IDLE accept vector | MAX argmax scan | EXP rom lookup + sum | DIV normalise | DONE hold result
module softmax_stream #(
    parameter int NUM_CLASSES = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int LUT_SIZE    = 256,
    parameter int LUT_WIDTH   = 16,
    parameter int EXP_SHIFT   = 0,
    parameter int PROB_WIDTH  = 16,
    parameter int ARGMAX_ONLY = 0,
    localparam int CLASS_W    = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_logits,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_CLASSES*PROB_WIDTH-1:0] out_prob,
    output logic [CLASS_W-1:0]                out_class
);

    localparam bit AM = (ARGMAX_ONLY != 0);

    typedef enum logic [2:0] {S_IDLE, S_MAX, S_EXP, S_DIV, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [CLASS_W-1:0]           cls_q, cls_d;
    logic [CLASS_W-1:0]           arg_q, arg_d;
    logic [CLASS_W-1:0]           out_class_q, out_class_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic signed [DATA_WIDTH-1:0] logit_q [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] cur_logit;
    logic                         out_valid_q, out_valid_d;
    logic                         cls_last, bit_last, accept;

    // exp(-k/16) in Q60: Taylor series for exp(-1/16), then k rounded multiplies
    function automatic logic [LUT_WIDTH-1:0] exp_entry(input int k);
        logic [127:0] one, step, term, val, scaled;
        one  = 128'd1 << 60;
        step = one;
        term = one;
        for (int n = 1; n < 16; n++) begin
            term = term / 128'(16 * n);
            if (n % 2 == 1) step = step - term;
            else            step = step + term;
        end
        val = one;
        for (int j = 0; j < k; j++) val = (val * step + (one >> 1)) >> 60;
        scaled = (val * ((128'd1 << LUT_WIDTH) - 128'd1) + (one >> 1)) >> 60;
        return scaled[LUT_WIDTH-1:0];
    endfunction

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign cur_logit = logit_q[cls_q];
    assign cls_last  = (cls_q == CLASS_W'(NUM_CLASSES - 1));
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cls_q       <= '0;
            arg_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) logit_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            arg_q       <= arg_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            if (accept) begin
                for (int k = 0; k < NUM_CLASSES; k++)
                    logit_q[k] <= in_logits[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        arg_d       = arg_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_MAX;
                    cls_d   = '0;
                    arg_d   = '0;
                    max_d   = signed'(in_logits[DATA_WIDTH-1:0]);
                end
            end
            S_MAX: begin
                // strict compare keeps the lowest index on ties
                if (cur_logit > max_q) begin
                    max_d = cur_logit;
                    arg_d = cls_q;
                end
                if (cls_last) begin
                    cls_d   = '0;
                    state_d = AM ? S_DONE : S_EXP;
                end else begin
                    cls_d = cls_q + CLASS_W'(1);
                end
            end
            S_EXP: begin
                if (cls_last) begin
                    cls_d   = '0;
                    state_d = S_DIV;
                end else begin
                    cls_d = cls_q + CLASS_W'(1);
                end
            end
            S_DIV: begin
                if (bit_last) begin
                    if (cls_last) begin
                        cls_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cls_d = cls_q + CLASS_W'(1);
                    end
                end
            end
            S_DONE: begin
                // first DONE cycle registers the result, then it is held until taken
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_class_d = arg_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    generate
        if (AM) begin : g_argmax
            assign out_prob = '0;
            assign bit_last = 1'b0;
        end else begin : g_softmax
            localparam int IDX_W  = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;
            localparam int SUM_W  = LUT_WIDTH + CLASS_W + 1;
            localparam int REM_W  = SUM_W + 1;
            localparam int BIT_W  = (PROB_WIDTH > 1) ? $clog2(PROB_WIDTH) : 1;
            localparam int DIFF_W = DATA_WIDTH + 1;

            logic [LUT_WIDTH-1:0]  rom [LUT_SIZE];
            logic [LUT_WIDTH-1:0]  e_q [NUM_CLASSES];
            logic [PROB_WIDTH-1:0] prob_q [NUM_CLASSES];
            logic [DIFF_W-1:0]     diff, diff_sh;
            logic [IDX_W-1:0]      idx;
            logic [LUT_WIDTH-1:0]  e_cur, e_div;
            logic [SUM_W-1:0]      sum_q;
            logic [REM_W-1:0]      rem_q, r_cur, r_dbl, r_nxt;
            logic [PROB_WIDTH-1:0] quo_q, quo_base, quo_nxt;
            logic [BIT_W-1:0]      bit_q;
            logic                  ge, sat;

            for (genvar g = 0; g < LUT_SIZE; g++) begin : g_rom
                localparam logic [LUT_WIDTH-1:0] ENTRY = exp_entry(g);
                assign rom[g] = ENTRY;
            end

            always_comb begin
                diff    = {max_q[DATA_WIDTH-1], max_q} - {cur_logit[DATA_WIDTH-1], cur_logit};
                diff_sh = diff >> EXP_SHIFT;
                idx     = (diff_sh > DIFF_W'(LUT_SIZE - 1)) ? IDX_W'(LUT_SIZE - 1) : IDX_W'(diff_sh);
                e_cur   = rom[idx];
                e_div   = e_q[cls_q];
                // e_i <= sum, so the only quotient that overflows is e_i == sum
                sat      = (SUM_W'(e_div) >= sum_q);
                r_cur    = (bit_q == '0) ? REM_W'(e_div) : rem_q;
                r_dbl    = r_cur << 1;
                ge       = (r_dbl >= REM_W'(sum_q));
                r_nxt    = ge ? (r_dbl - REM_W'(sum_q)) : r_dbl;
                quo_base = (bit_q == '0) ? '0 : quo_q;
                quo_nxt  = (quo_base << 1) | PROB_WIDTH'(ge);
            end

            assign bit_last = (bit_q == BIT_W'(PROB_WIDTH - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q <= '0;
                    rem_q <= '0;
                    quo_q <= '0;
                    bit_q <= '0;
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        e_q[k]    <= '0;
                        prob_q[k] <= '0;
                    end
                end else begin
                    if (accept) sum_q <= '0;
                    if (state_q == S_EXP) begin
                        e_q[cls_q] <= e_cur;
                        sum_q      <= sum_q + SUM_W'(e_cur);
                    end
                    if (state_q == S_DIV) begin
                        rem_q <= r_nxt;
                        quo_q <= quo_nxt;
                        if (bit_last) begin
                            bit_q         <= '0;
                            prob_q[cls_q] <= sat ? '1 : quo_nxt;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end
            end

            for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pack
                assign out_prob[g*PROB_WIDTH +: PROB_WIDTH] = prob_q[g];
            end
        end
    endgenerate

endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: directed vectors against softmax_stream in N=4, N=2 and argmax-only N=8 builds.
module tb_softmax_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0]  a_logits, a_prob;
    logic [1:0]   a_class;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]  b_logits, b_prob;
    logic [0:0]   b_class;
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [127:0] c_logits, c_prob;
    logic [2:0]   c_class;

    softmax_stream #(.NUM_CLASSES(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_logits(a_logits),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_prob(a_prob), .out_class(a_class)
    );

    softmax_stream #(.NUM_CLASSES(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_logits(b_logits),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_prob(b_prob), .out_class(b_class)
    );

    softmax_stream #(.NUM_CLASSES(8), .ARGMAX_ONLY(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_logits(c_logits),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_prob(c_prob), .out_class(c_class)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input int q0, input int q1, input int q2,
                           input int q3, input int cls);
        int q[4];
        q = '{q0, q1, q2, q3};
        for (int i = 0; i < 4; i++)
            check($sformatf("%s.q%0d", tag, i), 64'(a_prob[i*16 +: 16]), 64'(q[i]));
        check({tag, ".class"}, 64'(a_class), 64'(cls));
    endtask

    function automatic logic [63:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
    endfunction

    task automatic send_a(input logic [63:0] v, output int lat);
        check("a.in_ready_before_send", 64'(a_in_ready), 64'd1);
        a_logits   = v;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 500) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int cv[8];
        cv = '{3, -1, 9, 9, 0, 2, -7, 1};
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_logits = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_logits = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_logits = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(a_out_valid), 64'd0);
        check("rst.in_ready",  64'(a_in_ready),  64'd1);
        check("rst.out_prob",  a_prob,           64'd0);
        check("rst.out_class", 64'(a_class),     64'd0);
        check("rst.c_in_ready", 64'(c_in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // all-equal logits: uniform 1/4
        send_a(pack4(0, 0, 0, 0), lat);
        check("eq.latency", 64'(lat), 64'd73);
        check_a("eq", 16384, 16384, 16384, 16384, 0);
        @(posedge clk); #1;
        check("eq.in_ready_after", 64'(a_in_ready), 64'd1);
        check("eq.out_valid_after", 64'(a_out_valid), 64'd0);

        // tie at max and most-negative logit; sum = 2*65535 + 30957 + 0 = 162027
        send_a(pack4(-5, 7, 7, -32768), lat);
        check("tie.latency", 64'(lat), 64'd73);
        check_a("tie", 12521, 26507, 26507, 0, 1);
        @(posedge clk); #1;

        // backpressure: result held, new vector refused
        a_out_ready = 1'b0;
        send_a(pack4(-4000, -4000, 50, 50), lat);
        check("bp.latency", 64'(lat), 64'd73);
        check_a("bp", 0, 0, 32768, 32768, 2);
        a_logits   = pack4(100, 0, 0, 0);
        a_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", 64'(a_out_valid), 64'd1);
            check("bp.hold_in_ready", 64'(a_in_ready), 64'd0);
            check("bp.hold_prob", a_prob, 64'h8000_8000_0000_0000);
            check("bp.hold_class", 64'(a_class), 64'd2);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release_valid", 64'(a_out_valid), 64'd0);
        check("bp.release_in_ready", 64'(a_in_ready), 64'd1);

        // reset in the middle of the divide phase
        a_logits   = pack4(1, 2, 3, 4);
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst.out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst.in_ready",  64'(a_in_ready),  64'd1);
        check("mid_rst.out_prob",  a_prob,           64'd0);
        check("mid_rst.out_class", 64'(a_class),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst.in_ready", 64'(a_in_ready), 64'd1);
        check("post_rst.out_valid", 64'(a_out_valid), 64'd0);
        send_a(pack4(7, -5, -32768, 7), lat);
        check("post_rst.latency", 64'(lat), 64'd73);
        check_a("post_rst", 26507, 12521, 0, 26507, 0);
        @(posedge clk); #1;

        // N=2 dominant class saturates
        check("dom.in_ready", 64'(b_in_ready), 64'd1);
        b_logits   = {16'(1000), 16'(-2000)};
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 500) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dom.latency", 64'(lat), 64'd37);
        check("dom.q0", 64'(b_prob[15:0]), 64'd0);
        check("dom.q1", 64'(b_prob[31:16]), 64'd65535);
        check("dom.class", 64'(b_class), 64'd1);
        @(posedge clk); #1;

        // argmax-only, N=8
        for (int i = 0; i < 8; i++) c_logits[i*16 +: 16] = 16'(cv[i]);
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        lat = 0;
        while (!c_out_valid && lat < 500) begin
            @(posedge clk); #1;
            lat++;
        end
        check("am.latency", 64'(lat), 64'd9);
        check("am.class", 64'(c_class), 64'd2);
        check("am.prob_lo", c_prob[63:0], 64'd0);
        check("am.prob_hi", c_prob[127:64], 64'd0);
        @(posedge clk); #1;
        check("am.in_ready_after", 64'(c_in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
